// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin arbiter sharing one pipelined Wishbone slave bus
// between NUMM masters. Ownership lasts for a master's whole cyc burst.
// Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN (limit = TIMEOUT cycles).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no owner, grant = 0, slave side quiet, rotation pick pending
// GRANTED | master 'last' owns the bus, slave side follows its inputs
// ABORT   | watchdog fired, owner held off the bus until it drops cyc
module wb_rr_arbiter #(
    parameter int NUMM    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUMM-1:0]   m_cyc,
    input  logic [NUMM-1:0]   m_stb,
    input  logic [NUMM-1:0]   m_we,
    input  logic [4*NUMM-1:0] m_sel,
    input  logic [32*NUMM-1:0] m_adr,
    input  logic [32*NUMM-1:0] m_dat_w,
    output logic [NUMM-1:0]   m_ack,
    output logic [NUMM-1:0]   m_err,
    output logic [NUMM-1:0]   m_stall,
    output logic [31:0]       m_dat_r,
    output logic              s_cyc,
    output logic              s_stb,
    output logic              s_we,
    output logic [3:0]        s_sel,
    output logic [31:0]       s_adr,
    output logic [31:0]       s_dat_w,
    input  logic              s_ack,
    input  logic              s_err,
    input  logic              s_stall,
    input  logic [31:0]       s_dat_r,
    output logic [NUMM-1:0]   grant,
    output logic              tmo
);

    localparam int IW = (NUMM > 1) ? $clog2(NUMM) : 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NUMM - 1);

    // Reject illegal parameterisations at elaboration.
    if (NUMM < 2 || NUMM > 8 || TIMEOUT < 4 || TIMEOUT > 65535) begin : g_param_check
        $error("wb_rr_arbiter: NUMM must be 2..8 and TIMEOUT 4..65535");
    end

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, GRANTED = 2'd1, ABORT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, GRANTED = 2'd1} state_t;
`endif

    state_t          state, state_nx;
    logic [NUMM-1:0] grant_nx;
    logic [IW-1:0]   last, last_nx;
    logic [IW-1:0]   win_idx;
    logic            win_found;
    logic            own_cyc;
    logic            hit;
    int unsigned     own;

    // While granted, 'last' is the owner index.
    assign own     = 32'(last);
    assign own_cyc = m_cyc[own];
    assign m_dat_r = s_dat_r;
    assign tmo     = hit;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LIM = 16'(TIMEOUT - 1);
    logic [15:0] wd_cnt;

    // Slave response on the limit cycle wins over the abort.
    assign hit = (state == GRANTED) && own_cyc && !s_ack && !s_err && (wd_cnt == WD_LIM);

    // Watchdog: counts cycles of an active owner cycle with no slave response.
    always_ff @(posedge clk) begin
        if (rst)
            wd_cnt <= '0;
        else if (state != GRANTED || !own_cyc || s_ack || s_err || hit)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 16'd1;
    end
`else
    assign hit = 1'b0;
`endif

    // Rotation pick: first requester after the most recent owner.
    always_comb begin
        logic [IW-1:0] idx;
        win_found = 1'b0;
        win_idx   = last;
        idx       = last;
        for (int k = 1; k <= NUMM; k++) begin
            idx = IW'((int'(last) + k) % NUMM);
            if (!win_found && m_cyc[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    // State, grant and rotation pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            last  <= LAST_RST;
        end else begin
            state <= state_nx;
            grant <= grant_nx;
            last  <= last_nx;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx = state;
        grant_nx = grant;
        last_nx  = last;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nx = GRANTED;
                    grant_nx = {{(NUMM-1){1'b0}}, 1'b1} << win_idx;
                    last_nx  = win_idx;
                end
            end
            GRANTED: begin
                if (!own_cyc) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (hit) begin
                    state_nx = ABORT;
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            ABORT: begin
                if (!own_cyc) begin
                    state_nx = IDLE;
                    grant_nx = '0;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
                grant_nx = '0;
            end
        endcase
    end

    // Bus steering: owner's signals to the slave, slave response to the owner.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_sel   = '0;
        s_adr   = '0;
        s_dat_w = '0;
        m_ack   = '0;
        m_err   = '0;
        m_stall = '1;
        if (state == GRANTED) begin
            s_cyc        = own_cyc && !hit;
            s_stb        = own_cyc && m_stb[own] && !hit;
            s_we         = m_we[own];
            s_sel        = m_sel[4*own +: 4];
            s_adr        = m_adr[32*own +: 32];
            s_dat_w      = m_dat_w[32*own +: 32];
            m_ack[own]   = s_ack && !hit;
            m_err[own]   = s_err || hit;
            m_stall[own] = s_stall || hit;
        end
    end

endmodule
